// File: rtl/flex_stp_pkg.sv
// -----------------------------------------------------------------------------
// flex_stp_pkg
// Shared types and helpers for the flex serial/parallel family.
//   slot_state_t : output-slot occupancy for a word handed to a consumer
//   beats_f      : number of lane-wide beats that make up one word
// -----------------------------------------------------------------------------
package flex_stp_pkg;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_t;

   // Kept as a function so a matching serializer derives the same beat count.
   function automatic int beats_f(input int num_bits, input int lane_w);
      return num_bits / lane_w;
   endfunction

endpackage

// File: rtl/flex_lane_sr.sv
// -----------------------------------------------------------------------------
// flex_lane_sr
// Lane-wide shift register. Each enabled cycle one LANE_W beat is shifted in,
// either at the LSB end (SHIFT_MSB=1, moving toward the MSB) or at the MSB end
// (SHIFT_MSB=0, moving toward the LSB).
// Ports:
//   clk_i           clock
//   n_rst_i         synchronous active-low reset (loads RESET_VAL)
//   clear_i         synchronous flush (loads RESET_VAL), beats shift_enable_i
//   shift_enable_i  shift serial_in_i in this cycle
//   serial_in_i     beat data
//   sr_o            current register contents
//   sr_next_o       value the register takes if this cycle shifts
// -----------------------------------------------------------------------------
module flex_lane_sr #(
   parameter int                     NUM_BITS  = 8,
   parameter int                     LANE_W    = 1,
   parameter int                     SHIFT_MSB = 1,
   parameter logic [NUM_BITS-1:0]    RESET_VAL = '1
) (
   input  logic                clk_i,
   input  logic                n_rst_i,
   input  logic                clear_i,
   input  logic                shift_enable_i,
   input  logic [LANE_W-1:0]   serial_in_i,
   output logic [NUM_BITS-1:0] sr_o,
   output logic [NUM_BITS-1:0] sr_next_o
);

   logic [NUM_BITS-1:0] sr_q;
   logic [NUM_BITS-1:0] sr_d;
   logic [NUM_BITS-1:0] to_msb;
   logic [NUM_BITS-1:0] to_lsb;

   assign to_msb    = {sr_q[NUM_BITS-LANE_W-1:0], serial_in_i};
   assign to_lsb    = {serial_in_i, sr_q[NUM_BITS-1:LANE_W]};
   assign sr_next_o = (SHIFT_MSB != 0) ? to_msb : to_lsb;
   assign sr_o      = sr_q;

   always_comb begin
      sr_d = sr_q;
      if (shift_enable_i) begin
         sr_d = sr_next_o;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!n_rst_i || clear_i) begin
         sr_q <= RESET_VAL;
      end else begin
         sr_q <= sr_d;
      end
   end

endmodule

// File: rtl/flex_stp_deser.sv
// -----------------------------------------------------------------------------
// flex_stp_deser
// Serial-to-parallel deserializer. Collects NUM_BITS/LANE_W beats into a word
// and offers it through a one-entry valid/ready output slot. A word completing
// while the slot is still held is dropped and flags a sticky overrun.
// Ports:
//   clk_i           clock
//   n_rst_i         synchronous active-low reset
//   clear_i         synchronous flush of framing, pending word and overrun
//   shift_enable_i  accept serial_in_i this cycle
//   serial_in_i     beat data (LANE_W bits)
//   partial_out_o   live shift-register contents
//   beat_count_o    beats collected in the current word
//   word_out_o      completed word, stable while word_valid_o
//   word_valid_o    completed word pending
//   word_ready_i    consumer accepts word_out_o
//   overrun_o       sticky: a completed word was dropped
// -----------------------------------------------------------------------------
module flex_stp_deser
   import flex_stp_pkg::*;
#(
   parameter int                  NUM_BITS  = 8,
   parameter int                  LANE_W    = 1,
   parameter int                  SHIFT_MSB = 1,
   parameter logic [NUM_BITS-1:0] RESET_VAL = '1
) (
   input  logic                                 clk_i,
   input  logic                                 n_rst_i,
   input  logic                                 clear_i,
   input  logic                                 shift_enable_i,
   input  logic [LANE_W-1:0]                    serial_in_i,
   output logic [NUM_BITS-1:0]                  partial_out_o,
   output logic [$clog2(NUM_BITS/LANE_W)-1:0]   beat_count_o,
   output logic [NUM_BITS-1:0]                  word_out_o,
   output logic                                 word_valid_o,
   input  logic                                 word_ready_i,
   output logic                                 overrun_o
);

   localparam int                BEATS     = beats_f(NUM_BITS, LANE_W);
   localparam int                CNT_W     = $clog2(BEATS);
   localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

   if ((NUM_BITS % LANE_W) != 0 || BEATS < 2) begin : g_param_check
      $error("flex_stp_deser: NUM_BITS must be a multiple of LANE_W with at least two beats");
   end

   logic [NUM_BITS-1:0] sr_next;
   slot_state_t         state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [NUM_BITS-1:0] word_q, word_d;
   logic                ovr_q, ovr_d;
   logic                completion;

   flex_lane_sr #(
      .NUM_BITS  (NUM_BITS),
      .LANE_W    (LANE_W),
      .SHIFT_MSB (SHIFT_MSB),
      .RESET_VAL (RESET_VAL)
   ) u_sr (
      .clk_i          (clk_i),
      .n_rst_i        (n_rst_i),
      .clear_i        (clear_i),
      .shift_enable_i (shift_enable_i),
      .serial_in_i    (serial_in_i),
      .sr_o           (partial_out_o),
      .sr_next_o      (sr_next)
   );

   // Reset and clear are handled in the register process, so completion here
   // only needs to look at the enable and the framing counter.
   assign completion = shift_enable_i && (cnt_q == LAST_BEAT);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      ovr_d   = ovr_q;

      if (shift_enable_i) begin
         cnt_d = completion ? '0 : cnt_q + 1'b1;
      end

      case (state_q)
         SLOT_EMPTY: begin
            if (completion) begin
               state_d = SLOT_FULL;
               word_d  = sr_next;   // captured word includes the final beat
            end
         end
         SLOT_FULL: begin
            if (completion) begin
               if (word_ready_i) begin
                  word_d = sr_next;  // old word consumed this cycle, slot refills
               end else begin
                  ovr_d  = 1'b1;     // held word wins, new one is dropped
               end
            end else if (word_ready_i) begin
               state_d = SLOT_EMPTY;
            end
         end
         default: state_d = SLOT_EMPTY;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!n_rst_i || clear_i) begin
         state_q <= SLOT_EMPTY;
         cnt_q   <= '0;
         word_q  <= RESET_VAL;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         ovr_q   <= ovr_d;
      end
   end

   assign beat_count_o = cnt_q;
   assign word_out_o   = word_q;
   assign word_valid_o = (state_q == SLOT_FULL);
   assign overrun_o    = ovr_q;

endmodule

// File: tb/tb_flex_stp_deser.sv
// -----------------------------------------------------------------------------
// tb_flex_stp_deser
// Two instances: 8-bit/1-lane shifting toward the MSB (m) and 8-bit/2-lane
// shifting toward the LSB (l). A word-level model tracks each instance and is
// compared against every output on every falling edge; directed literal
// expectations pin the model at the key points.
// -----------------------------------------------------------------------------
module tb_flex_stp_deser;

   logic       clk = 1'b0;
   logic       n_rst, clr;
   logic       en_m, ser_m, rdy_m;
   logic       en_l, rdy_l;
   logic [1:0] ser_l;

   logic [7:0] partial_m, word_m, partial_l, word_l;
   logic [2:0] cnt_m;
   logic [1:0] cnt_l;
   logic       valid_m, ovr_m, valid_l, ovr_l;

   int  n_cmp = 0;
   int  n_bad = 0;
   bit  chk_on = 1'b0;

   // model state, index 0 = m, 1 = l
   int  m_sr[2], m_word[2], m_cnt[2];
   bit  m_valid[2], m_ovr[2];

   always #5 clk = ~clk;

   flex_stp_deser #(.NUM_BITS(8), .LANE_W(1), .SHIFT_MSB(1), .RESET_VAL(8'hFF)) dut_m (
      .clk_i(clk), .n_rst_i(n_rst), .clear_i(clr), .shift_enable_i(en_m),
      .serial_in_i(ser_m), .partial_out_o(partial_m), .beat_count_o(cnt_m),
      .word_out_o(word_m), .word_valid_o(valid_m), .word_ready_i(rdy_m),
      .overrun_o(ovr_m));

   flex_stp_deser #(.NUM_BITS(8), .LANE_W(2), .SHIFT_MSB(0), .RESET_VAL(8'hFF)) dut_l (
      .clk_i(clk), .n_rst_i(n_rst), .clear_i(clr), .shift_enable_i(en_l),
      .serial_in_i(ser_l), .partial_out_o(partial_l), .beat_count_o(cnt_l),
      .word_out_o(word_l), .word_valid_o(valid_l), .word_ready_i(rdy_l),
      .overrun_o(ovr_l));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Word-level model: a word is BEATS beats; the register value is built
   // arithmetically from the beat sequence.
   task automatic model_step(input int k, input int lane, input bit msb,
                             input bit en, input int beat, input bit rdy);
      bit comp;
      int beats;
      beats = 8 / lane;
      if (!n_rst || clr) begin
         m_sr[k] = 255; m_word[k] = 255; m_cnt[k] = 0; m_valid[k] = 0; m_ovr[k] = 0;
      end else begin
         comp = en && (m_cnt[k] == beats - 1);
         if (en) begin
            if (msb) m_sr[k] = (m_sr[k] * (2 ** lane) + beat) % 256;
            else     m_sr[k] = m_sr[k] / (2 ** lane) + beat * (2 ** (8 - lane));
            m_cnt[k] = comp ? 0 : m_cnt[k] + 1;
         end
         if (comp) begin
            if (!m_valid[k] || rdy) begin
               m_valid[k] = 1;
               m_word[k]  = m_sr[k];
            end else begin
               m_ovr[k] = 1;
            end
         end else if (m_valid[k] && rdy) begin
            m_valid[k] = 0;
         end
      end
   endtask

   always @(posedge clk) begin
      model_step(0, 1, 1'b1, en_m, int'(ser_m), rdy_m);
      model_step(1, 2, 1'b0, en_l, int'(ser_l), rdy_l);
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("m.partial", 32'(partial_m), m_sr[0]);
         chk("m.beat_count", 32'(cnt_m), m_cnt[0]);
         chk("m.word_out", 32'(word_m), m_word[0]);
         chk("m.word_valid", 32'(valid_m), 32'(m_valid[0]));
         chk("m.overrun", 32'(ovr_m), 32'(m_ovr[0]));
         chk("l.partial", 32'(partial_l), m_sr[1]);
         chk("l.beat_count", 32'(cnt_l), m_cnt[1]);
         chk("l.word_out", 32'(word_l), m_word[1]);
         chk("l.word_valid", 32'(valid_l), 32'(m_valid[1]));
         chk("l.overrun", 32'(ovr_l), 32'(m_ovr[1]));
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Shift a full word into m, MSB first; ready asserted only with the final beat.
   task automatic feed_m(input logic [7:0] w, input logic rdy_last);
      for (int i = 7; i >= 0; i--) begin
         en_m  = 1'b1;
         ser_m = w[i];
         rdy_m = (i == 0) ? rdy_last : 1'b0;
         tick();
      end
      en_m  = 1'b0;
      rdy_m = 1'b0;
   endtask

   task automatic chk_reset_m(input string tag);
      chk({tag, ".m.partial"}, 32'(partial_m), 32'h FF);
      chk({tag, ".m.word"}, 32'(word_m), 32'h FF);
      chk({tag, ".m.cnt"}, 32'(cnt_m), 32'd0);
      chk({tag, ".m.valid"}, 32'(valid_m), 32'd0);
      chk({tag, ".m.ovr"}, 32'(ovr_m), 32'd0);
   endtask

   logic [7:0] wa5;
   logic [1:0] lb[4];
   logic [1:0] lb2[4];

   initial begin
      n_rst = 1'b0; clr = 1'b0;
      en_m = 1'b0; ser_m = 1'b0; rdy_m = 1'b0;
      en_l = 1'b0; ser_l = 2'b00; rdy_l = 1'b0;
      wa5 = 8'hA5;
      lb  = '{2'b01, 2'b10, 2'b11, 2'b00};
      lb2 = '{2'b10, 2'b01, 2'b11, 2'b10};

      // reset
      tick(); tick();
      chk_on = 1'b1;
      chk_reset_m("reset");
      chk("reset.l.partial", 32'(partial_l), 32'hFF);
      chk("reset.l.valid", 32'(valid_l), 32'd0);
      n_rst = 1'b1;

      // m: 8'hA5 one bit per beat; l: four 2-bit beats in parallel
      for (int i = 0; i < 8; i++) begin
         en_m  = 1'b1;
         ser_m = wa5[7 - i];
         if (i < 4) begin
            en_l  = 1'b1;
            ser_l = lb[i];
         end else begin
            en_l  = 1'b0;
         end
         tick();
         if (i < 4) chk("l.beat_seq", 32'(cnt_l), 32'((i + 1) % 4));
         if (i == 3) begin
            chk("l.word_39", 32'(word_l), 32'h39);
            chk("l.valid_after_last", 32'(valid_l), 32'd1);
         end
         if (i == 6) chk("m.valid_before_last", 32'(valid_m), 32'd0);
      end
      en_m = 1'b0; en_l = 1'b0;
      chk("m.word_A5", 32'(word_m), 32'hA5);
      chk("m.valid_after_last", 32'(valid_m), 32'd1);
      chk("m.cnt_wrap", 32'(cnt_m), 32'd0);

      // slot held: second word must be dropped, overrun sticky
      feed_m(8'h3C, 1'b0);
      chk("m.word_held", 32'(word_m), 32'hA5);
      chk("m.overrun_set", 32'(ovr_m), 32'd1);
      chk("m.partial_3C", 32'(partial_m), 32'h3C);
      for (int i = 0; i < 3; i++) begin
         ser_m = i[0];
         tick();
      end
      chk("m.idle_hold", 32'(partial_m), 32'h3C);
      chk("m.overrun_sticky", 32'(ovr_m), 32'd1);

      // clear beats shift_enable
      en_m = 1'b1; ser_m = 1'b1; en_l = 1'b1; ser_l = 2'b11; clr = 1'b1;
      tick();
      clr = 1'b0; en_m = 1'b0; en_l = 1'b0;
      chk_reset_m("clear");
      chk("clear.l.cnt", 32'(cnt_l), 32'd0);

      // ready coincident with the final beat of word2 reloads the slot
      feed_m(8'h5A, 1'b0);
      chk("m.word_5A", 32'(word_m), 32'h5A);
      feed_m(8'hC3, 1'b1);
      chk("m.word_C3", 32'(word_m), 32'hC3);
      chk("m.valid_kept", 32'(valid_m), 32'd1);
      chk("m.no_overrun", 32'(ovr_m), 32'd0);
      rdy_m = 1'b1;
      tick();
      rdy_m = 1'b0;
      chk("m.drained", 32'(valid_m), 32'd0);
      chk("m.word_stable", 32'(word_m), 32'hC3);

      // l: beats separated by idle cycles
      for (int i = 0; i < 4; i++) begin
         en_l = 1'b1; ser_l = lb2[i];
         tick();
         en_l = 1'b0; ser_l = 2'b01;
         tick();
      end
      chk("l.word_B6_gaps", 32'(word_l), 32'hB6);

      // reset mid-word discards partial beats
      for (int i = 0; i < 3; i++) begin
         en_m = 1'b1; ser_m = (i != 2);
         tick();
      end
      en_m = 1'b0; n_rst = 1'b0;
      tick();
      n_rst = 1'b1;
      chk_reset_m("midreset");
      feed_m(8'h96, 1'b0);
      chk("m.word_96", 32'(word_m), 32'h96);
      chk("m.valid_96", 32'(valid_m), 32'd1);
      tick();

      chk_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
